// File: rtl/new_flow_notif_queue.sv
// Multi-source new-flow notification queue: arbitrates NUM_SRC requesters into a FWFT FIFO.
// Optional per-source statistics counters are enabled by defining NEW_FLOW_Q_STATS_EN.
`ifndef FLOW_ID_W
`define FLOW_ID_W 16
`endif
`ifndef FLOW_LOOKUP_ENTRY_WIDTH
`define FLOW_LOOKUP_ENTRY_WIDTH 32
`endif
`ifndef ACK_NUM_WIDTH
`define ACK_NUM_WIDTH 32
`endif

module new_flow_notif_queue #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FLOWID_W = `FLOW_ID_W,
    parameter int unsigned ENTRY_W  = `FLOW_LOOKUP_ENTRY_WIDTH,
    parameter int unsigned ACK_W    = `ACK_NUM_WIDTH,
    parameter int unsigned ARB_MODE = 0,
    localparam int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_new_flow_val,
    output logic [NUM_SRC-1:0]          src_new_flow_rdy,
    input  logic [NUM_SRC*FLOWID_W-1:0] src_new_flow_flowid,
    input  logic [NUM_SRC*ENTRY_W-1:0]  src_new_flow_lookup_entry,
    input  logic [NUM_SRC*ACK_W-1:0]    src_new_flow_init_ack_num,
    output logic                        new_flow_val,
    input  logic                        new_flow_rdy,
    output logic [FLOWID_W-1:0]         new_flow_flowid,
    output logic [ENTRY_W-1:0]          new_flow_lookup_entry,
    output logic [ACK_W-1:0]            new_flow_init_ack_num,
    output logic [SRC_W-1:0]            new_flow_src,
`ifdef NEW_FLOW_Q_STATS_EN
    output logic [NUM_SRC*32-1:0]       stat_accept_cnt,
    output logic [NUM_SRC*32-1:0]       stat_stall_cnt,
    output logic [CNT_W-1:0]            stat_hwm,
`endif
    output logic [CNT_W-1:0]            q_count,
    output logic                        q_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [ENTRY_W-1:0]  entry;
        logic [ACK_W-1:0]    ack;
        logic [SRC_W-1:0]    src;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              wdata_d;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    grant_idx, arb_idx;
    logic [NUM_SRC-1:0]  grant;
    logic                any_grant, push, pop;

    logic [FLOWID_W-1:0] in_fid [NUM_SRC];
    logic [ENTRY_W-1:0]  in_ent [NUM_SRC];
    logic [ACK_W-1:0]    in_ack [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign in_fid[g] = src_new_flow_flowid[g*FLOWID_W +: FLOWID_W];
        assign in_ent[g] = src_new_flow_lookup_entry[g*ENTRY_W +: ENTRY_W];
        assign in_ack[g] = src_new_flow_init_ack_num[g*ACK_W +: ACK_W];
    end

    // Rotating search from rr_ptr in round-robin mode, plain index order in fixed priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        arb_idx   = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            arb_idx = (ARB_MODE == 0) ? SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC) : SRC_W'(k);
            if (!any_grant && src_new_flow_val[arb_idx]) begin
                any_grant        = 1'b1;
                grant_idx        = arb_idx;
                grant[arb_idx]   = 1'b1;
            end
        end
    end

    assign src_new_flow_rdy = rst ? '0 : (grant & {NUM_SRC{!full_q}});

    always_comb begin
        push     = any_grant && !full_q && !rst;
        pop      = (count_q != '0) && new_flow_rdy;
        wdata_d  = '{flowid: in_fid[grant_idx], entry: in_ent[grant_idx],
                     ack: in_ack[grant_idx], src: grant_idx};
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        rr_ptr_d = rr_ptr_q;
        if (ARB_MODE == 0 && push) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset: head outputs are forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_d;
        end
    end

    assign new_flow_val          = (count_q != '0);
    assign head                  = new_flow_val ? mem_q[rd_ptr_q] : '0;
    assign new_flow_flowid       = head.flowid;
    assign new_flow_lookup_entry = head.entry;
    assign new_flow_init_ack_num = head.ack;
    assign new_flow_src          = head.src;
    assign q_count               = count_q;
    assign q_full                = full_q;

`ifdef NEW_FLOW_Q_STATS_EN
    logic [NUM_SRC*32-1:0] acc_q, acc_d, stall_q, stall_d;
    logic [CNT_W-1:0]      hwm_q, hwm_d;

    always_comb begin
        acc_d   = acc_q;
        stall_d = stall_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_new_flow_val[i] && src_new_flow_rdy[i]) begin
                acc_d[i*32 +: 32] = acc_q[i*32 +: 32] + 32'd1;
            end
            if (src_new_flow_val[i] && !src_new_flow_rdy[i]) begin
                stall_d[i*32 +: 32] = stall_q[i*32 +: 32] + 32'd1;
            end
        end
        hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            stall_q <= '0;
            hwm_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            stall_q <= stall_d;
            hwm_q   <= hwm_d;
        end
    end

    assign stat_accept_cnt = acc_q;
    assign stat_stall_cnt  = stall_q;
    assign stat_hwm        = hwm_q;
`endif

endmodule

// File: tb/tb_new_flow_notif_queue.sv
// Bench for new_flow_notif_queue: directed vector table, hand sequences and a queue-based model.
module tb_new_flow_notif_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src_val;
    logic [31:0] src_fid;
    logic [63:0] src_ent, src_ack;
    logic        nrdy;

    logic [1:0]  rdy_rr, rdy_fp;
    logic        val_rr, val_fp, full_rr, full_fp;
    logic [15:0] fid_rr, fid_fp;
    logic [31:0] ent_rr, ent_fp, ack_rr, ack_fp;
    logic        src_rr, src_fp;
    logic [3:0]  cnt_rr, cnt_fp;
`ifdef NEW_FLOW_Q_STATS_EN
    logic [63:0] st_acc_rr, st_stall_rr, st_acc_fp, st_stall_fp;
    logic [3:0]  st_hwm_rr, st_hwm_fp;
`endif

    always #5 clk = ~clk;

    new_flow_notif_queue #(.NUM_SRC(2), .DEPTH(DEPTH), .FLOWID_W(16), .ENTRY_W(32), .ACK_W(32),
                           .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .src_new_flow_val(src_val), .src_new_flow_rdy(rdy_rr),
        .src_new_flow_flowid(src_fid), .src_new_flow_lookup_entry(src_ent),
        .src_new_flow_init_ack_num(src_ack),
        .new_flow_val(val_rr), .new_flow_rdy(nrdy), .new_flow_flowid(fid_rr),
        .new_flow_lookup_entry(ent_rr), .new_flow_init_ack_num(ack_rr), .new_flow_src(src_rr),
`ifdef NEW_FLOW_Q_STATS_EN
        .stat_accept_cnt(st_acc_rr), .stat_stall_cnt(st_stall_rr), .stat_hwm(st_hwm_rr),
`endif
        .q_count(cnt_rr), .q_full(full_rr)
    );

    new_flow_notif_queue #(.NUM_SRC(2), .DEPTH(DEPTH), .FLOWID_W(16), .ENTRY_W(32), .ACK_W(32),
                           .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .src_new_flow_val(src_val), .src_new_flow_rdy(rdy_fp),
        .src_new_flow_flowid(src_fid), .src_new_flow_lookup_entry(src_ent),
        .src_new_flow_init_ack_num(src_ack),
        .new_flow_val(val_fp), .new_flow_rdy(nrdy), .new_flow_flowid(fid_fp),
        .new_flow_lookup_entry(ent_fp), .new_flow_init_ack_num(ack_fp), .new_flow_src(src_fp),
`ifdef NEW_FLOW_Q_STATS_EN
        .stat_accept_cnt(st_acc_fp), .stat_stall_cnt(st_stall_fp), .stat_hwm(st_hwm_fp),
`endif
        .q_count(cnt_fp), .q_full(full_fp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] fid;
        logic [31:0] ent;
        logic [31:0] ack;
        logic        src;
    } item_t;

    item_t      mq[$];
    item_t      pend[2];
    logic [1:0] sv;
    int         rr_m;
    int         fid_ctr;
    int         acc_src[$];
    int         out_fid[$];

    task automatic drive();
        src_val = sv;
        src_fid = {pend[1].fid, pend[0].fid};
        src_ent = {pend[1].ent, pend[0].ent};
        src_ack = {pend[1].ack, pend[0].ack};
    endtask

    // One cycle against the reference queue: expected grant is the first requester at or
    // after the round-robin pointer, and only if fewer than DEPTH entries are held.
    task automatic mcycle(input logic nrdy_i);
        int         win;
        logic [1:0] er;
        item_t      h;
        item_t      it;
        nrdy = nrdy_i;
        drive();
        #1;
        win = -1;
        if (mq.size() < DEPTH) begin
            for (int k = 0; k < 2; k++) begin
                int s;
                s = (rr_m + k) % 2;
                if (win < 0 && sv[s]) win = s;
            end
        end
        er = 2'b00;
        if (win >= 0) er[win] = 1'b1;
        check("src_rdy", rdy_rr, er);
        check("val", val_rr, mq.size() != 0);
        check("count", cnt_rr, mq.size());
        check("full", full_rr, mq.size() == DEPTH);
        if (mq.size() != 0) begin
            h = mq[0];
            check("head_fid", fid_rr, h.fid);
            check("head_ent", ent_rr, h.ent);
            check("head_ack", ack_rr, h.ack);
            check("head_src", src_rr, h.src);
        end
        @(posedge clk);
        if (mq.size() != 0 && nrdy_i) begin
            h = mq.pop_front();
            out_fid.push_back(int'(h.fid));
        end
        if (win >= 0) begin
            it     = pend[win];
            it.src = win[0];
            mq.push_back(it);
            acc_src.push_back(win);
            rr_m          = (win + 1) % 2;
            sv[win]       = 1'b0;
            pend[win].fid = 16'(fid_ctr);
            pend[win].ent = $urandom;
            pend[win].ack = $urandom;
            fid_ctr++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sv   = 2'b00;
        nrdy = 1'b0;
        drive();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mq.delete();
        acc_src.delete();
        out_fid.delete();
        rr_m = 0;
    endtask

    typedef struct {
        logic        v0;
        logic [15:0] fid;
        logic [31:0] ack;
        logic        nrdy;
        logic        e_val;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_rdy0;
        logic [15:0] e_fid;
        logic [31:0] e_ack;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Single push with ready consumer, then fill to full and the pop-without-push cycle.
        tbl[0]  = '{1'b1, 16'h05, 32'h1000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 16'h0, 32'h0};
        tbl[1]  = '{1'b0, 16'h00, 32'h0,    1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 16'h05, 32'h1000};
        tbl[2]  = '{1'b0, 16'h00, 32'h0,    1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 32'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[3+k] = '{1'b1, 16'h10 + 16'(k), 32'h2000 + 32'(k), 1'b0, (k != 0), 4'(k),
                         1'b0, 1'b1, 16'h10, 32'h2000};
        end
        tbl[11] = '{1'b1, 16'h18, 32'h2008, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 16'h10, 32'h2000};
        tbl[12] = '{1'b1, 16'h18, 32'h2008, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 16'h10, 32'h2000};
        tbl[13] = '{1'b1, 16'h18, 32'h2008, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 16'h11, 32'h2001};
        tbl[14] = '{1'b0, 16'h00, 32'h0,    1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 16'h11, 32'h2001};

        sv = 2'b01;
        pend[0] = '{16'h33, 32'h0, 32'h44, 1'b0};
        pend[1] = '{16'h55, 32'h0, 32'h66, 1'b0};
        nrdy = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", rdy_rr, 2'b00);
        check("reset_rdy_fp", rdy_fp, 2'b00);
        check("reset_val", val_rr, 1'b0);
        check("reset_count", cnt_rr, 4'd0);
        check("reset_full", full_rr, 1'b0);
        check("reset_fid", fid_rr, 16'h0);
        check("reset_ack", ack_rr, 32'h0);
        check("reset_src", src_rr, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            src_val = {1'b0, tbl[i].v0};
            src_fid = {16'h0, tbl[i].fid};
            src_ent = 64'h0;
            src_ack = {32'h0, tbl[i].ack};
            nrdy    = tbl[i].nrdy;
            #1;
            check($sformatf("tbl%0d_rdy", i), rdy_rr, {1'b0, tbl[i].e_rdy0});
            check($sformatf("tbl%0d_val", i), val_rr, tbl[i].e_val);
            check($sformatf("tbl%0d_count", i), cnt_rr, tbl[i].e_cnt);
            check($sformatf("tbl%0d_full", i), full_rr, tbl[i].e_full);
            if (tbl[i].e_val) begin
                check($sformatf("tbl%0d_fid", i), fid_rr, tbl[i].e_fid);
                check($sformatf("tbl%0d_ack", i), ack_rr, tbl[i].e_ack);
            end
            @(posedge clk);
            #1;
        end

        // Reset while holding five entries, then first push after reset.
        src_val = 2'b00;
        nrdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_count", cnt_rr, 4'd5);
        rst     = 1'b1;
        nrdy    = 1'b0;
        src_val = 2'b01;
        src_fid = {16'h0, 16'h77};
        src_ack = {32'h0, 32'h7};
        #1;
        check("rst_rdy_low", rdy_rr, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_val", val_rr, 1'b0);
        check("post_rst_count", cnt_rr, 4'd0);
        check("post_rst_full", full_rr, 1'b0);
`ifdef NEW_FLOW_Q_STATS_EN
        check("post_rst_acc", st_acc_rr, 64'h0);
        check("post_rst_stall", st_stall_rr, 64'h0);
        check("post_rst_hwm", st_hwm_rr, 4'd0);
`endif
        check("post_rst_rdy", rdy_rr, 2'b01);
        @(posedge clk);
        #1;
        check("post_rst_latency_val", val_rr, 1'b1);
        check("post_rst_fid", fid_rr, 16'h77);
        check("post_rst_ack", ack_rr, 32'h7);
        check("post_rst_cnt", cnt_rr, 4'd1);

        // Round-robin with both sources permanently requesting.
        do_reset();
        fid_ctr = 16'h300;
        pend[0] = '{16'h100, $urandom, $urandom, 1'b0};
        pend[1] = '{16'h200, $urandom, $urandom, 1'b0};
        for (int i = 0; i < 8; i++) begin
            sv = 2'b11;
            mcycle(1'b1);
        end
        sv = 2'b00;
        repeat (2) mcycle(1'b1);
        check("rr_accepts", acc_src.size(), 8);
        for (int k = 0; k < acc_src.size(); k++) begin
            check($sformatf("rr_order%0d", k), acc_src[k], k % 2);
        end

        // Fixed priority instance: src0 always wins.
        do_reset();
        sv = 2'b11;
        for (int i = 0; i < 4; i++) begin
            nrdy = 1'b1;
            drive();
            #1;
            check($sformatf("fp_rdy%0d", i), rdy_fp, 2'b01);
            if (i > 0) check($sformatf("fp_src%0d", i), src_fp, 1'b0);
            @(posedge clk);
            #1;
        end

        // Wrap-around: 20 ordered flow IDs from src0 with a random consumer.
        do_reset();
        pend[0] = '{16'h0, $urandom, $urandom, 1'b0};
        fid_ctr = 1;
        for (int g = 0; g < 300 && acc_src.size() < 20; g++) begin
            sv = 2'b01;
            mcycle(1'($urandom_range(0, 1)));
            check("wrap_cnt_bound", cnt_rr <= 4'd8, 1'b1);
        end
        sv = 2'b00;
        for (int g = 0; g < 30 && mq.size() != 0; g++) mcycle(1'b1);
        check("wrap_out_count", out_fid.size(), 20);
        for (int k = 0; k < out_fid.size() && k < 20; k++) begin
            check($sformatf("wrap_fid%0d", k), out_fid[k], k);
        end

        // Random traffic on both sources, first with a slow consumer, then a fast one.
        do_reset();
        fid_ctr = 16'h1000;
        pend[0] = '{16'h0a00, $urandom, $urandom, 1'b0};
        pend[1] = '{16'h0b00, $urandom, $urandom, 1'b0};
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!sv[s]) sv[s] = 1'($urandom_range(0, 1));
            end
            if (c < 200) mcycle($urandom_range(0, 3) == 0);
            else         mcycle($urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
